goose_motion_ctrl: RTL and testbench
====================================

// Module: goose_motion_ctrl
// PURPOSE
// - Per-frame motion/pose sequencer for the player goose in goose-run.
// - Turns jump/slide button requests into a goose state (stand/run/jump/slide/dead).
// - Outputs the sprite pose select and the goose bottom row to the sprite renderers.
// - The renderers (run, jump and slide poses) stay combinational and read pose/goose_y.
// - All state changes are aligned to frame_tick, so no sprite tears mid-frame.
// PARAMETERS
// - Y_W          10   width of row coordinates
// - GROUND_Y     380  goose bottom row when grounded
// - JUMP_H       96   apex height in pixels above GROUND_Y; must be < GROUND_Y
// - JUMP_STEP    4    pixels per frame while rising or falling
// - HANG_FRAMES  6    frames held at apex
// - SLIDE_MIN    20   minimum slide duration in frames
// - ANIM_DIV     8    frames per run-animation phase toggle
// PORTS
// - clk         in   1    system clock
// - rst_n       in   1    synchronous reset, active-low
// - frame_tick  in   1    one-cycle pulse per video frame
// - game_run    in   1    level: game in progress
// - game_over   in   1    level: collision detected
// - btn_jump    in   1    debounced level, high while pressed
// - btn_slide   in   1    debounced level, high while pressed
// - pose        out  3    POSE_* code for the sprite mux
// - goose_y     out  Y_W  goose bottom row: GROUND_Y - height
// - airborne    out  1    1 in RISE/HANG/FALL
// - sliding     out  1    1 in SLIDE (low hitbox)
// BEHAVIOUR
// - Clock and reset: one clock; reset is synchronous and active-low.
// - Reset values: state=IDLE, pose=POSE_STAND, goose_y=GROUND_Y, airborne=0, sliding=0.
//   All counters and latched requests clear on reset.
// - Request latches:
//   - A rising edge of btn_jump or btn_slide sets a sticky request flag (jreq/sreq).
//   - Flags clear on the frame_tick that consumes them, or on any state change into IDLE or DEAD.
// - Update rule: state, counters and outputs update only on cycles where frame_tick=1.
//   Registered outputs are valid the cycle after the tick.
// - States and transitions (evaluated on frame_tick; priority in the order listed):
//   - Any state, game_over=1 -> DEAD. Outputs are frozen except pose=POSE_DEAD.
//   - DEAD -> IDLE when game_run=0. IDLE is height 0, pose STAND.
//   - IDLE -> RUN when game_run=1. Anim counter restarts at RUN_A.
//   - RUN:
//     - jreq -> RISE. This includes the jreq & sreq case: jump wins and sreq is discarded.
//     - sreq alone -> SLIDE, slide counter = 0.
//     - Otherwise the anim counter counts; every ANIM_DIV frames pose toggles RUN_A <-> RUN_B.
//   - RISE: h += JUMP_STEP, saturating at JUMP_H. On reaching JUMP_H -> HANG.
//   - HANG: counts HANG_FRAMES frames, then -> FALL.
//   - FALL:
//     - h -= JUMP_STEP, or 2*JUMP_STEP while btn_slide is held (fast-fall); saturates at 0.
//     - At h=0: if btn_slide is held -> SLIDE, else -> RUN.
//   - SLIDE:
//     - Counts frames, saturating. Exit -> RUN once count >= SLIDE_MIN-1 and btn_slide=0.
//     - jreq during SLIDE -> RISE immediately.
//   - jreq and sreq arriving in RISE, HANG or FALL are discarded.
// - Pose mapping: RISE/HANG/FALL -> POSE_JUMP; SLIDE -> POSE_SLIDE.
// - Arithmetic:
//   - h is an unsigned counter of $clog2(JUMP_H+1)+1 bits.
//   - goose_y = GROUND_Y - h, never below GROUND_Y-JUMP_H; no wrap permitted.
// - game_run falling edge while in RUN/RISE/HANG/FALL/SLIDE -> IDLE on the next tick; h snaps to 0.
// - Reset asserted mid-jump: on the next clk, outputs are at reset values regardless of frame_tick.
// STRUCTURE
// - goose_pkg holds:
//   - POSE_STAND=0, POSE_RUN_A=1, POSE_RUN_B=2, POSE_JUMP=3, POSE_SLIDE=4, POSE_DEAD=5
//   - the state enum localparams
//   - GROUND_Y shared with the obstacle and collision logic
// - Sub-module goose_btn_req: edge detect plus sticky flag with a clear input; one instance per button.
// TESTING
// - Reset, game_run=1, 16 ticks -> pose RUN_A for ticks 1-8, RUN_B for 9-16; goose_y=380.
// - Jump pulse in RUN -> 24 rising ticks to goose_y=284, 6 HANG ticks, 24 FALL ticks to 380, then RUN.
// - btn_slide held through FALL from apex -> 12 fall ticks, land in SLIDE.
//   Release after 5 frames -> SLIDE persists to frame 20, then RUN.
// - btn_jump and btn_slide rising in the same cycle while in RUN -> RISE; no SLIDE follows.
// - game_over at h=48 -> pose=DEAD, goose_y frozen at 332. game_run=0 -> IDLE, goose_y=380.
// - rst_n=0 mid-HANG with no frame_tick -> next cycle pose=STAND, goose_y=380, airborne=0.

Source files
------------

// File: rtl/goose_pkg.sv
// Shared constants and types for the goose motion sequencer and its neighbours
// (obstacle and collision logic read GROUND_Y from here).
package goose_pkg;

    localparam int GROUND_Y = 380;

    typedef logic [2:0] pose_t;

    localparam pose_t POSE_STAND  = 3'd0;
    localparam pose_t POSE_RUN_A  = 3'd1;
    localparam pose_t POSE_RUN_B  = 3'd2;
    localparam pose_t POSE_JUMP   = 3'd3;
    localparam pose_t POSE_SLIDE  = 3'd4;
    localparam pose_t POSE_DEAD   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_RISE  = 3'd2,
        ST_HANG  = 3'd3,
        ST_FALL  = 3'd4,
        ST_SLIDE = 3'd5,
        ST_DEAD  = 3'd6
    } state_t;

    function automatic logic is_air(input state_t s);
        return (s == ST_RISE) || (s == ST_HANG) || (s == ST_FALL);
    endfunction

endpackage

// File: rtl/goose_btn_req.sv
// Button request latch: a rising edge of the debounced button sets a sticky
// flag that holds until the sequencer clears it. A new edge beats a clear.
module goose_btn_req (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    input  logic i_clr,
    output logic o_req
);

    logic r_prev;
    logic r_req;
    logic w_rise;

    assign w_rise = i_btn & ~r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
            r_req  <= 1'b0;
        end else begin
            r_prev <= i_btn;
            r_req  <= w_rise | (r_req & ~i_clr);
        end
    end

    assign o_req = r_req;

endmodule

// File: rtl/goose_motion_ctrl.sv
// Per-frame goose pose sequencer: turns jump/slide requests into a motion state,
// a sprite pose and the goose bottom row. Everything advances only on frame_tick.
module goose_motion_ctrl #(
    parameter int Y_W         = 10,
    parameter int GROUND_Y    = goose_pkg::GROUND_Y,
    parameter int JUMP_H      = 96,
    parameter int JUMP_STEP   = 4,
    parameter int HANG_FRAMES = 6,
    parameter int SLIDE_MIN   = 20,
    parameter int ANIM_DIV    = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_frame_tick,
    input  logic           i_game_run,
    input  logic           i_game_over,
    input  logic           i_btn_jump,
    input  logic           i_btn_slide,
    output logic [2:0]     o_pose,
    output logic [Y_W-1:0] o_goose_y,
    output logic           o_airborne,
    output logic           o_sliding
);

    import goose_pkg::*;

    localparam int H_W  = $clog2(JUMP_H + 1) + 1;
    localparam int A_W  = $clog2(ANIM_DIV + 1);
    localparam int HF_W = $clog2(HANG_FRAMES + 1);
    localparam int S_W  = $clog2(SLIDE_MIN + 1);

    localparam logic [H_W-1:0]  H_MAX   = H_W'(JUMP_H);
    localparam logic [H_W-1:0]  H_STEP  = H_W'(JUMP_STEP);
    localparam logic [H_W-1:0]  H_STEP2 = H_W'(2 * JUMP_STEP);
    localparam logic [A_W-1:0]  A_LAST  = A_W'(ANIM_DIV - 1);
    localparam logic [HF_W-1:0] HF_LAST = HF_W'(HANG_FRAMES - 1);
    localparam logic [S_W-1:0]  S_LAST  = S_W'(SLIDE_MIN - 1);

    state_t          r_state, w_nstate;
    logic [H_W-1:0]  r_h, w_h;
    logic [A_W-1:0]  r_anim, w_anim;
    logic            r_phase, w_phase;
    logic [HF_W-1:0] r_hang, w_hang;
    logic [S_W-1:0]  r_scnt, w_scnt;
    pose_t           r_pose, w_pose;
    logic [Y_W-1:0]  r_y, w_y;
    logic            r_air, w_air;
    logic            r_sl, w_sl;

    logic            w_jreq, w_sreq, w_clr;
    logic [H_W-1:0]  w_h_up, w_h_dn, w_dec;

    // Every tick consumes or discards pending requests, except the IDLE->RUN
    // start tick, so a press made just before the game starts is not lost.
    assign w_clr = i_frame_tick && !(r_state == ST_IDLE && w_nstate == ST_RUN);

    goose_btn_req u_jreq (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_jump),
        .i_clr   (w_clr),
        .o_req   (w_jreq)
    );

    goose_btn_req u_sreq (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_slide),
        .i_clr   (w_clr),
        .o_req   (w_sreq)
    );

    // Saturating height steps; compares are done before the add/subtract so nothing wraps.
    assign w_dec  = i_btn_slide ? H_STEP2 : H_STEP;
    assign w_h_up = (r_h >= H_MAX - H_STEP) ? H_MAX : r_h + H_STEP;
    assign w_h_dn = (r_h <= w_dec) ? '0 : r_h - w_dec;

    always_comb begin
        w_nstate = r_state;
        w_h      = r_h;
        w_anim   = r_anim;
        w_phase  = r_phase;
        w_hang   = r_hang;
        w_scnt   = r_scnt;

        if (i_game_over) begin
            w_nstate = ST_DEAD;
        end else if (r_state == ST_DEAD) begin
            if (!i_game_run) w_nstate = ST_IDLE;
        end else if (r_state == ST_IDLE) begin
            if (i_game_run) begin
                w_nstate = ST_RUN;
                w_anim   = '0;
                w_phase  = 1'b0;
            end
        end else if (!i_game_run) begin
            w_nstate = ST_IDLE;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_jreq) begin
                        w_nstate = ST_RISE;
                    end else if (w_sreq) begin
                        w_nstate = ST_SLIDE;
                        w_scnt   = '0;
                    end else if (r_anim == A_LAST) begin
                        w_anim  = '0;
                        w_phase = ~r_phase;
                    end else begin
                        w_anim = r_anim + 1'b1;
                    end
                end
                ST_RISE: begin
                    w_h = w_h_up;
                    if (w_h_up == H_MAX) begin
                        w_nstate = ST_HANG;
                        w_hang   = '0;
                    end
                end
                ST_HANG: begin
                    if (r_hang == HF_LAST) w_nstate = ST_FALL;
                    else                   w_hang   = r_hang + 1'b1;
                end
                ST_FALL: begin
                    w_h = w_h_dn;
                    if (w_h_dn == '0) begin
                        if (i_btn_slide) begin
                            w_nstate = ST_SLIDE;
                            w_scnt   = '0;
                        end else begin
                            w_nstate = ST_RUN;
                            w_anim   = '0;
                            w_phase  = 1'b0;
                        end
                    end
                end
                ST_SLIDE: begin
                    if (w_jreq) begin
                        w_nstate = ST_RISE;
                    end else if (r_scnt >= S_LAST && !i_btn_slide) begin
                        w_nstate = ST_RUN;
                        w_anim   = '0;
                        w_phase  = 1'b0;
                    end else if (r_scnt < S_LAST) begin
                        w_scnt = r_scnt + 1'b1;
                    end
                end
                default: w_nstate = ST_IDLE;
            endcase
        end

        if (w_nstate == ST_IDLE) w_h = '0;
    end

    // DEAD freezes the sprite in place; only the pose changes.
    always_comb begin
        w_pose = r_pose;
        w_y    = r_y;
        w_air  = r_air;
        w_sl   = r_sl;
        if (w_nstate == ST_DEAD) begin
            w_pose = POSE_DEAD;
        end else begin
            w_y   = Y_W'(GROUND_Y) - Y_W'(w_h);
            w_air = is_air(w_nstate);
            w_sl  = (w_nstate == ST_SLIDE);
            case (w_nstate)
                ST_RUN:                    w_pose = w_phase ? POSE_RUN_B : POSE_RUN_A;
                ST_RISE, ST_HANG, ST_FALL: w_pose = POSE_JUMP;
                ST_SLIDE:                  w_pose = POSE_SLIDE;
                default:                   w_pose = POSE_STAND;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_h     <= '0;
            r_anim  <= '0;
            r_phase <= 1'b0;
            r_hang  <= '0;
            r_scnt  <= '0;
            r_pose  <= POSE_STAND;
            r_y     <= Y_W'(GROUND_Y);
            r_air   <= 1'b0;
            r_sl    <= 1'b0;
        end else if (i_frame_tick) begin
            r_state <= w_nstate;
            r_h     <= w_h;
            r_anim  <= w_anim;
            r_phase <= w_phase;
            r_hang  <= w_hang;
            r_scnt  <= w_scnt;
            r_pose  <= w_pose;
            r_y     <= w_y;
            r_air   <= w_air;
            r_sl    <= w_sl;
        end
    end

    assign o_pose     = r_pose;
    assign o_goose_y  = r_y;
    assign o_airborne = r_air;
    assign o_sliding  = r_sl;

endmodule

// File: tb/tb_goose_motion_ctrl.sv
// Bench for goose_motion_ctrl: vector table for run/jump, directed corner
// sequences, then random stimulus against a frame-level reference model.
module tb_goose_motion_ctrl;

    localparam int GY = 380, JH = 96, JS = 4, HF = 6, SM = 20, AD = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_RISE = 2, M_HANG = 3, M_FALL = 4, M_SLIDE = 5, M_DEAD = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, tick = 1'b0, run = 1'b0, over = 1'b0, bj = 1'b0, bs = 1'b0;
    logic [2:0] pose;
    logic [9:0] gy;
    logic       air, sl;

    int n_chk = 0, n_pass = 0;
    bit chk_model = 0;

    goose_motion_ctrl #(
        .Y_W(10), .GROUND_Y(GY), .JUMP_H(JH), .JUMP_STEP(JS),
        .HANG_FRAMES(HF), .SLIDE_MIN(SM), .ANIM_DIV(AD)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(tick), .i_game_run(run),
        .i_game_over(over), .i_btn_jump(bj), .i_btn_slide(bs),
        .o_pose(pose), .o_goose_y(gy), .o_airborne(air), .o_sliding(sl)
    );

    always #5 clk = ~clk;

    // Reference model: mode, height in pixels, frames spent in the current mode.
    int m_mode, m_h, m_fr, m_pose, m_y;
    bit m_air, m_sl, m_jr, m_sr, m_pj, m_ps;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk_all(input string nm, input int p, input int y, input int a, input int s);
        chk({nm, "_pose"}, pose, p);
        chk({nm, "_y"}, gy, y);
        chk({nm, "_air"}, air, a);
        chk({nm, "_sl"}, sl, s);
    endtask

    task automatic model_edge();
        int nm;
        bit clr;
        if (!rst_n) begin
            m_mode = M_IDLE; m_h = 0; m_fr = 0; m_pose = 0; m_y = GY;
            m_air = 0; m_sl = 0; m_jr = 0; m_sr = 0; m_pj = 0; m_ps = 0;
        end else begin
            clr = tick;
            if (tick) begin
                nm = m_mode;
                if (over) nm = M_DEAD;
                else if (m_mode == M_DEAD) begin
                    if (!run) nm = M_IDLE;
                end else if (m_mode == M_IDLE) begin
                    if (run) begin nm = M_RUN; m_fr = 0; clr = 0; end
                end else if (!run) nm = M_IDLE;
                else case (m_mode)
                    M_RUN: begin
                        if (m_jr) nm = M_RISE;
                        else if (m_sr) begin nm = M_SLIDE; m_fr = 0; end
                        else m_fr++;
                    end
                    M_RISE: begin
                        m_h = (m_h + JS > JH) ? JH : m_h + JS;
                        if (m_h == JH) begin nm = M_HANG; m_fr = 0; end
                    end
                    M_HANG: begin
                        m_fr++;
                        if (m_fr == HF) nm = M_FALL;
                    end
                    M_FALL: begin
                        m_h = m_h - (bs ? 2 * JS : JS);
                        if (m_h < 0) m_h = 0;
                        if (m_h == 0) begin nm = bs ? M_SLIDE : M_RUN; m_fr = 0; end
                    end
                    default: begin
                        if (m_jr) nm = M_RISE;
                        else if (m_fr >= SM - 1 && !bs) begin nm = M_RUN; m_fr = 0; end
                        else m_fr++;
                    end
                endcase
                if (nm == M_DEAD) m_pose = 5;
                else begin
                    if (nm == M_IDLE) m_h = 0;
                    m_y   = GY - m_h;
                    m_air = (nm == M_RISE || nm == M_HANG || nm == M_FALL);
                    m_sl  = (nm == M_SLIDE);
                    case (nm)
                        M_IDLE:  m_pose = 0;
                        M_RUN:   m_pose = ((m_fr / AD) % 2 == 0) ? 1 : 2;
                        M_SLIDE: m_pose = 4;
                        default: m_pose = 3;
                    endcase
                end
                m_mode = nm;
            end
            m_jr = (bj && !m_pj) || (m_jr && !clr);
            m_sr = (bs && !m_ps) || (m_sr && !clr);
            m_pj = bj;
            m_ps = bs;
        end
    endtask

    task automatic step(input bit t);
        tick = t;
        @(posedge clk);
        model_edge();
        #1;
        tick = 1'b0;
        if (chk_model) chk_all("model", m_pose, m_y, m_air, m_sl);
    endtask

    task automatic frame();
        step(1'b0);
        step(1'b1);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic jump_pulse();
        bj = 1'b1;
        frame();
        bj = 1'b0;
    endtask

    typedef struct {
        int reps;
        bit run, over, bj, bs;
        int pose, y0, dy;
        bit air, sl;
    } vec_t;

    vec_t vt[9];

    initial begin
        // reps, run, over, bj, bs, pose, y0, dy, air, sl
        vt[0] = '{1,  1, 0, 0, 0, 1, 380,  0, 0, 0};
        vt[1] = '{7,  1, 0, 0, 0, 1, 380,  0, 0, 0};
        vt[2] = '{8,  1, 0, 0, 0, 2, 380,  0, 0, 0};
        vt[3] = '{1,  1, 0, 1, 0, 3, 380,  0, 1, 0};
        vt[4] = '{24, 1, 0, 0, 0, 3, 376, -4, 1, 0};
        vt[5] = '{6,  1, 0, 0, 0, 3, 284,  0, 1, 0};
        vt[6] = '{23, 1, 0, 0, 0, 3, 288,  4, 1, 0};
        vt[7] = '{1,  1, 0, 0, 0, 1, 380,  0, 0, 0};
        vt[8] = '{1,  1, 0, 0, 0, 1, 380,  0, 0, 0};

        rst_n = 1'b0;
        step(1'b0);
        step(1'b0);
        chk_all("reset", 0, 380, 0, 0);
        rst_n = 1'b1;
        step(1'b0);

        for (int v = 0; v < 9; v++) begin
            for (int k = 0; k < vt[v].reps; k++) begin
                run = vt[v].run; over = vt[v].over; bj = vt[v].bj; bs = vt[v].bs;
                frame();
                chk_all($sformatf("tbl%0d_%0d", v, k), vt[v].pose, vt[v].y0 + vt[v].dy * k,
                        vt[v].air, vt[v].sl);
            end
        end
        bj = 1'b0;

        // Fast-fall from apex with slide held lands in SLIDE; minimum slide length.
        jump_pulse();
        frames(24);
        frames(6);
        chk_all("ff_apex", 3, 284, 1, 0);
        bs = 1'b1;
        frames(11);
        chk_all("ff_fall11", 3, 372, 1, 0);
        frame();
        chk_all("ff_land", 4, 380, 0, 1);
        frames(4);
        bs = 1'b0;
        frames(15);
        chk_all("slide_f20", 4, 380, 0, 1);
        frame();
        chk_all("slide_exit", 1, 380, 0, 0);

        // Jump and slide pressed together: jump wins, slide request dropped.
        bj = 1'b1; bs = 1'b1;
        frame();
        bj = 1'b0; bs = 1'b0;
        chk_all("both_rise", 3, 380, 1, 0);
        frames(53);
        chk_all("both_fall", 3, 376, 1, 0);
        frame();
        chk_all("both_land", 1, 380, 0, 0);
        frame();
        chk_all("both_noslide", 1, 380, 0, 0);

        // Collision mid-rise freezes height; game_run low returns to IDLE.
        jump_pulse();
        frames(12);
        chk_all("go_h48", 3, 332, 1, 0);
        over = 1'b1;
        frame();
        chk_all("go_dead", 5, 332, 1, 0);
        frames(3);
        chk_all("go_frozen", 5, 332, 1, 0);
        over = 1'b0; run = 1'b0;
        frame();
        chk_all("go_idle", 0, 380, 0, 0);

        // Synchronous reset mid-HANG without a frame tick.
        run = 1'b1;
        frame();
        jump_pulse();
        frames(26);
        chk_all("rst_hang", 3, 284, 1, 0);
        rst_n = 1'b0;
        step(1'b0);
        chk_all("rst_mid", 0, 380, 0, 0);
        rst_n = 1'b1;
        step(1'b0);

        // Random stimulus against the reference model.
        run = 1'b0; over = 1'b0; bj = 1'b0; bs = 1'b0;
        rst_n = 1'b0;
        step(1'b0);
        rst_n = 1'b1;
        run = 1'b1;
        chk_model = 1;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 9) == 0) bj = ~bj;
            if ($urandom_range(0, 11) == 0) bs = ~bs;
            if (run && $urandom_range(0, 299) == 0) run = 1'b0;
            else if (!run && $urandom_range(0, 19) == 0) run = 1'b1;
            if (!over && $urandom_range(0, 399) == 0) over = 1'b1;
            else if (over && $urandom_range(0, 9) == 0) over = 1'b0;
            rst_n = ($urandom_range(0, 1499) != 0);
            step($urandom_range(0, 2) == 0);
        end
        chk_model = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
